// File: rtl/bsg_cache_dma_responder_pkg.sv
// Shared helpers for the cache DMA responder: packet width arithmetic.
package bsg_cache_dma_responder_pkg;

    // Packet layout is {write_not_read, addr}.
    function automatic int unsigned bsg_cache_dma_pkt_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read word array with asynchronous read and no reset on contents.
module bsg_mem_1r1w #(
    parameter int unsigned width_p                = 32,
    parameter int unsigned els_p                  = 1024,
    parameter int unsigned read_write_same_addr_p = 0,
    parameter int unsigned addr_width_lp          = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    if (read_write_same_addr_p != 0) begin : g_bypass
        // A same-cycle write to the read address is forwarded.
        assign r_data_o = (w_v_i && (w_addr_i == r_addr_i)) ? w_data_i : mem_q[r_addr_i];
    end else begin : g_plain
        assign r_data_o = mem_q[r_addr_i];
    end

endmodule

// File: rtl/bsg_cache_dma_responder.sv
// Memory-side endpoint for the cache DMA port: streams refill blocks out and absorbs
// evicted blocks into an on-block word array.
module bsg_cache_dma_responder
    import bsg_cache_dma_responder_pkg::*;
#(
    parameter int unsigned addr_width_p          = 32,
    parameter int unsigned data_width_p          = 32,
    parameter int unsigned block_size_in_words_p = 8,
    parameter int unsigned els_p                 = 1024,
    parameter int unsigned latency_p             = 2
) (
    input  logic                                              clk_i,
    input  logic                                              reset_n_i,
    input  logic [bsg_cache_dma_pkt_width(addr_width_p)-1:0] dma_pkt_i,
    input  logic                                              dma_pkt_v_i,
    output logic                                              dma_pkt_yumi_o,
    output logic [data_width_p-1:0]                           dma_data_o,
    output logic                                              dma_data_v_o,
    input  logic                                              dma_data_ready_and_i,
    input  logic [data_width_p-1:0]                           dma_data_i,
    input  logic                                              dma_data_v_i,
    output logic                                              dma_data_yumi_o
);

    localparam int unsigned LgBytes = $clog2(data_width_p / 8);
    localparam int unsigned LgBlk   = $clog2(block_size_in_words_p);
    localparam int unsigned LgEls   = $clog2(els_p);
    localparam int unsigned BlkW    = LgEls - LgBlk;
    localparam int unsigned LatW    = (latency_p > 1) ? $clog2(latency_p) : 1;

    typedef struct packed {
        logic                    write_not_read;
        logic [addr_width_p-1:0] addr;
    } dma_pkt_s;

    typedef enum logic [1:0] {StIdle, StWait, StRead, StWrite} state_e;

    dma_pkt_s        pkt;
    logic [BlkW-1:0] pkt_blk;
    logic            unused_addr;

    assign pkt         = dma_pkt_i;
    // Word index drops byte-offset bits; block index also drops the beat bits and
    // anything above the array size, so addresses wrap.
    assign pkt_blk     = pkt.addr[LgBytes+LgEls-1:LgBytes+LgBlk];
    assign unused_addr = ^pkt.addr;

    state_e           state_q, state_d;
    logic [LgBlk-1:0] cnt_q, cnt_d;
    logic [LatW-1:0]  lat_q, lat_d;
    logic [BlkW-1:0]  blk_q, blk_d;
    logic             pkt_yumi;
    logic             data_v;
    logic             data_yumi;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lat_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        blk_d     = blk_q;
        pkt_yumi  = 1'b0;
        data_v    = 1'b0;
        data_yumi = 1'b0;

        unique case (state_q)
            StIdle: begin
                pkt_yumi = dma_pkt_v_i;
                if (dma_pkt_v_i) begin
                    blk_d = pkt_blk;
                    cnt_d = '0;
                    lat_d = '0;
                    if (pkt.write_not_read) begin
                        state_d = StWrite;
                    end else if (latency_p > 0) begin
                        state_d = StWait;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWait: begin
                if (lat_q == LatW'(latency_p - 1)) begin
                    state_d = StRead;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StRead: begin
                data_v = 1'b1;
                if (dma_data_ready_and_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrite: begin
                data_yumi = dma_data_v_i;
                if (dma_data_v_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The FSM already sits in IDLE during reset; gate so no packet looks consumed.
    assign dma_pkt_yumi_o  = pkt_yumi & reset_n_i;
    assign dma_data_v_o    = data_v;
    assign dma_data_yumi_o = data_yumi;

    logic [LgEls-1:0] mem_addr;
    assign mem_addr = {blk_q, cnt_q};

    bsg_mem_1r1w #(
        .width_p               (data_width_p),
        .els_p                 (els_p),
        .read_write_same_addr_p(0)
    ) u_mem (
        .w_clk_i (clk_i),
        .w_v_i   (data_yumi),
        .w_addr_i(mem_addr),
        .w_data_i(dma_data_i),
        .r_addr_i(mem_addr),
        .r_data_o(dma_data_o)
    );

endmodule

// File: tb/tb_bsg_cache_dma_responder.sv
// Directed bench for bsg_cache_dma_responder: writes, latency/stall reads, wrap,
// back-to-back packet blocking and reset mid-transfer.
module tb_bsg_cache_dma_responder;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [32:0] dma_pkt_i;
    logic        dma_pkt_v_i;
    logic        dma_pkt_yumi_o;
    logic [31:0] dma_data_o;
    logic        dma_data_v_o;
    logic        dma_data_ready_and_i;
    logic [31:0] dma_data_i;
    logic        dma_data_v_i;
    logic        dma_data_yumi_o;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [8];

    always #5 clk_i = ~clk_i;

    bsg_cache_dma_responder #(
        .addr_width_p         (32),
        .data_width_p         (32),
        .block_size_in_words_p(8),
        .els_p                (1024),
        .latency_p            (2)
    ) dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .dma_pkt_i           (dma_pkt_i),
        .dma_pkt_v_i         (dma_pkt_v_i),
        .dma_pkt_yumi_o      (dma_pkt_yumi_o),
        .dma_data_o          (dma_data_o),
        .dma_data_v_o        (dma_data_v_o),
        .dma_data_ready_and_i(dma_data_ready_and_i),
        .dma_data_i          (dma_data_i),
        .dma_data_v_i        (dma_data_v_i),
        .dma_data_yumi_o     (dma_data_yumi_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at posedge + 1.
    task automatic send_pkt(input logic wnr, input logic [31:0] addr);
        dma_pkt_v_i = 1'b1;
        dma_pkt_i   = {wnr, addr};
        @(negedge clk_i);
        check("pkt_accept", dma_pkt_yumi_o, 1);
        @(posedge clk_i); #1;
        dma_pkt_v_i = 1'b0;
    endtask

    task automatic write_body(input logic [31:0] v0, input logic [15:0] dvpat,
                              input int nbeats, input bit hold, input bit done);
        int beat = 0;
        int cyc  = 0;
        logic dv;
        while (beat < nbeats && cyc < 64) begin
            dv           = dvpat[cyc % 16];
            dma_data_v_i = dv;
            dma_data_i   = dv ? v0 + beat : 32'hDEAD_BEEF;
            @(negedge clk_i);
            check("wr_yumi", dma_data_yumi_o, dv);
            if (hold) check("pkt_blocked", dma_pkt_yumi_o, 0);
            if (dv) beat++;
            cyc++;
            @(posedge clk_i); #1;
        end
        dma_data_v_i = 1'b0;
        if (beat < nbeats) check("wr_timeout", beat, nbeats);
        if (done) begin
            dma_data_v_i = 1'b1;
            dma_data_i   = 32'hDEAD_BEEF;
            @(negedge clk_i);
            check("wr_done", dma_data_yumi_o, 0);
            if (hold) check("pkt_next", dma_pkt_yumi_o, 1);
            @(posedge clk_i); #1;
            dma_data_v_i = 1'b0;
            dma_pkt_v_i  = 1'b0;
        end
    endtask

    task automatic read_body(input logic [15:0] rdypat);
        int beat  = 0;
        int cyc   = 0;
        int waits = 0;
        bit seen  = 1'b0;
        logic rdy;
        while (beat < 8 && cyc < 64) begin
            rdy                  = rdypat[cyc % 16];
            dma_data_ready_and_i = rdy;
            @(negedge clk_i);
            if (dma_data_v_o === 1'b1) begin
                seen = 1'b1;
                check("rd_data", dma_data_o, exp_q[beat]);
                if (rdy) beat++;
            end else if (!seen) begin
                waits++;
            end else begin
                check("rd_valid", dma_data_v_o, 1);
            end
            cyc++;
            @(posedge clk_i); #1;
        end
        if (beat < 8) check("rd_timeout", beat, 8);
        check("rd_latency", waits, 2);
        dma_data_ready_and_i = 1'b1;
        @(negedge clk_i);
        check("rd_done", dma_data_v_o, 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        reset_n_i            = 1'b0;
        dma_pkt_v_i          = 1'b1;
        dma_pkt_i            = {1'b0, 32'h40};
        dma_data_ready_and_i = 1'b0;
        dma_data_i           = '0;
        dma_data_v_i         = 1'b0;

        // Reset holds every handshake low even with a packet offered.
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_pkt_yumi", dma_pkt_yumi_o, 0);
        check("rst_data_v", dma_data_v_o, 0);
        check("rst_data_yumi", dma_data_yumi_o, 0);
        #1 reset_n_i = 1'b1;
        #1 check("rel_pkt_yumi", dma_pkt_yumi_o, 1);
        #1 dma_pkt_v_i = 1'b0;
        @(posedge clk_i); #1;

        // Full write then read back.
        send_pkt(1'b1, 32'h40);
        write_body(32'hA0, 16'hFFFF, 8, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) exp_q[i] = 32'hA0 + i;
        send_pkt(1'b0, 32'h40);
        read_body(16'hFFFF);

        // Unaligned address starts at the block base; address above the array wraps.
        send_pkt(1'b0, 32'h44);
        read_body(16'hFFFF);
        send_pkt(1'b0, 32'h40 + 32'd4096);
        read_body(16'hFFFF);

        // Ready pattern 1,0,0,1 repeating.
        send_pkt(1'b0, 32'h40);
        read_body(16'h9999);

        // Write with valid gaps while a read packet waits.
        send_pkt(1'b1, 32'h80);
        dma_pkt_v_i = 1'b1;
        dma_pkt_i   = {1'b0, 32'h80};
        write_body(32'hD0, 16'hB6D5, 8, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) exp_q[i] = 32'hD0 + i;
        read_body(16'hFFFF);

        // Reset after 3 of 8 write beats.
        send_pkt(1'b1, 32'h100);
        write_body(32'hB0, 16'hFFFF, 8, 1'b0, 1'b1);
        send_pkt(1'b1, 32'h100);
        write_body(32'hC0, 16'hFFFF, 3, 1'b0, 1'b0);
        dma_pkt_v_i  = 1'b1;
        dma_pkt_i    = {1'b1, 32'h100};
        dma_data_v_i = 1'b1;
        dma_data_i   = 32'hEEEE_EEEE;
        reset_n_i    = 1'b0;
        #1;
        check("midrst_data_yumi", dma_data_yumi_o, 0);
        check("midrst_pkt_yumi", dma_pkt_yumi_o, 0);
        check("midrst_data_v", dma_data_v_o, 0);
        dma_pkt_v_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1 check("post_rst_idle", dma_data_yumi_o, 0);
        dma_data_v_i = 1'b0;
        @(posedge clk_i); #1;
        exp_q[0] = 32'hC0;
        exp_q[1] = 32'hC1;
        exp_q[2] = 32'hC2;
        for (int i = 3; i < 8; i++) exp_q[i] = 32'hB0 + i;
        send_pkt(1'b0, 32'h100);
        read_body(16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
